mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one unified 32-bit-word main memory between the CPU's instruction cache and data cache.
//  Grants one requester at a time and sequences the transfer on the memory side:
//   - a 4-beat block refill for the instruction cache (4 x 32 = 128 bits)
//   - a 1-beat read or write for the data cache
//  Sits between the CPU top level's two cache-to-memory interfaces and the single memory model.
// PARAMETERS
//  BLOCK_ADDR_W  6   cache block address width on both requester ports
//  WORD_W        32  memory word / data-cache block width
//  IBLOCK_WORDS  4   words per instruction block; fixed by the 128-bit INST_MEM_DATA
// PORTS
//  CLK                 in   1    clock; all state changes on the rising edge
//  RESET               in   1    synchronous, active-high reset
//  INST_MEM_READ       in   1    I-cache refill request; held until INST_MEM_BUSYWAIT=0
//  INST_MEM_ADDRESS    in   6    I-cache block address
//  INST_MEM_DATA       out  128  refilled block; beat k occupies [32k+31:32k]
//  INST_MEM_BUSYWAIT   out  1    I-cache stall
//  DATA_MEM_READ       in   1    D-cache read request
//  DATA_MEM_WRITE      in   1    D-cache write request
//  DATA_MEM_ADDRESS    in   6    D-cache block address
//  DATA_MEM_WRITEDATA  in   32   D-cache write block
//  DATA_MEM_READDATA   out  32   D-cache read block
//  DATA_MEM_BUSYWAIT   out  1    D-cache stall
//  MEM_READ            out  1    memory read strobe
//  MEM_WRITE           out  1    memory write strobe
//  MEM_ADDRESS         out  9    word address: inst {1'b1,blk,beat[1:0]}; data {1'b0,2'b00,blk}
//  MEM_WRITEDATA       out  32   memory write word
//  MEM_READDATA        in   32   memory read word
//  MEM_BUSYWAIT        in   1    high from the edge the memory samples a strobe until data/write done
// BEHAVIOUR
//  States:
//   - IDLE
//   - IBEAT (2-bit beat counter)
//   - DBEAT
//   - IDONE
//   - DDONE
//  Reset (sync) values:
//   - state=IDLE, beat=0, last_grant=INST
//   - INST_MEM_DATA=0, DATA_MEM_READDATA=0
//   - MEM_READ=MEM_WRITE=0
//   - Reset mid-transfer abandons the transfer; no output is updated.
//  Data requests:
//   - dreq = DATA_MEM_READ|DATA_MEM_WRITE.
//   - If both READ and WRITE are high, the request is a write.
//  Busywaits (combinational):
//   - INST_MEM_BUSYWAIT = INST_MEM_READ & ~(state==IDONE)
//   - DATA_MEM_BUSYWAIT = dreq & ~(state==DDONE)
//   - A requester sees busywait low for exactly one cycle per transfer.
//  Grant rule (IDLE):
//   - Grant only when MEM_BUSYWAIT=0; this covers a memory still busy after reset.
//   - Single requester: it is granted.
//   - Both requesting: grant the one not in last_grant (round-robin).
//   - After reset, a tie goes to data first.
//   - A grant updates last_grant.
//   - A grant is never pre-empted.
//  Beat timing:
//   - Issue cycle: strobe and address asserted; MEM_BUSYWAIT ignored.
//   - Following cycles: strobe held while MEM_BUSYWAIT=1.
//   - Completion cycle: first cycle after issue with MEM_BUSYWAIT=0.
//   - In the completion cycle the strobe is dropped combinationally, and MEM_READDATA is captured at the closing edge.
//  IBEAT:
//   - Beat k writes INST_MEM_DATA[32k+31:32k].
//   - After beat 3 go to IDONE; otherwise beat++ and re-issue next cycle.
//   - Beat counter wraps 3->0.
//  DBEAT:
//   - Read: captures DATA_MEM_READDATA.
//   - Write: drives MEM_WRITEDATA = DATA_MEM_WRITEDATA; no readdata update.
//   - Then go to DDONE.
//  IDONE/DDONE:
//   - One cycle, then IDLE.
//   - A request still high in the following IDLE is a new transfer.
//  Requester address/data are sampled continuously during the grant and must be held stable by the cache.
//  Latency with a memory that holds busywait LAT cycles:
//   - beat = LAT+2 cycles
//   - I refill = 4(LAT+2)+1 cycles from the grant edge to busywait low
//   - D transfer = LAT+3 cycles
// TESTING (memory model LAT=4)
//  1. Data read of blk 0x05, memory word 0x05 = 0xDEADBEEF
//     -> MEM_ADDRESS 0x005; DATA_MEM_READDATA=0xDEADBEEF; busywait low 7 cycles after grant.
//  2. Inst refill of blk 0x02, words 0x108..0x10B = 1,2,3,4
//     -> INST_MEM_DATA=0x00000004_00000003_00000002_00000001; busywait low 25 cycles after grant.
//  3. Inst and data requests in the same cycle right after reset
//     -> data granted first; inst granted in the IDLE after DDONE; next tie goes to data.
//  4. Data write 0x0000A5A5 to blk 0x3F
//     -> one MEM_WRITE beat to 0x03F with MEM_WRITEDATA=0x0000A5A5; DATA_MEM_READDATA unchanged.
//  5. RESET during inst beat 2
//     -> next cycle IDLE, strobes 0, INST_MEM_DATA=0; no new grant until MEM_BUSYWAIT=0.
//  6. Back-to-back inst refills with data idle
//     -> exactly one IDLE cycle between IDONE and the next IBEAT; MEM_READ never high in IDLE/DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one word memory between an I-cache block refill and a D-cache word access
module mem_arbiter #(
  parameter int BLOCK_ADDR_W = 6,
  parameter int WORD_W = 32,
  parameter int IBLOCK_WORDS = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           INST_MEM_READ,
  input  logic [BLOCK_ADDR_W-1:0]        INST_MEM_ADDRESS,
  output logic [IBLOCK_WORDS*WORD_W-1:0] INST_MEM_DATA,
  output logic                           INST_MEM_BUSYWAIT,
  input  logic                           DATA_MEM_READ,
  input  logic                           DATA_MEM_WRITE,
  input  logic [BLOCK_ADDR_W-1:0]        DATA_MEM_ADDRESS,
  input  logic [WORD_W-1:0]              DATA_MEM_WRITEDATA,
  output logic [WORD_W-1:0]              DATA_MEM_READDATA,
  output logic                           DATA_MEM_BUSYWAIT,
  output logic                           MEM_READ,
  output logic                           MEM_WRITE,
  output logic [BLOCK_ADDR_W+$clog2(IBLOCK_WORDS):0] MEM_ADDRESS,
  output logic [WORD_W-1:0]              MEM_WRITEDATA,
  input  logic [WORD_W-1:0]              MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
);
  localparam int BW = $clog2(IBLOCK_WORDS);
  typedef enum logic [2:0] {IDLE, IBEAT, DBEAT, IDONE, DDONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat;
  logic waiting, last_inst, dreq, dwr, in_beat, done, strobe, grant_d, grant_i;
  assign dreq = DATA_MEM_READ | DATA_MEM_WRITE;
  assign dwr = DATA_MEM_WRITE;
  assign in_beat = state == IBEAT || state == DBEAT;
  assign done = in_beat & waiting & ~MEM_BUSYWAIT;
  assign strobe = in_beat & ~done;
  assign grant_d = state == IDLE && !MEM_BUSYWAIT && dreq && (!INST_MEM_READ || last_inst);
  assign grant_i = state == IDLE && !MEM_BUSYWAIT && INST_MEM_READ && !grant_d;
  assign INST_MEM_BUSYWAIT = INST_MEM_READ & (state != IDONE);
  assign DATA_MEM_BUSYWAIT = dreq & (state != DDONE);
  assign MEM_READ = strobe & (state == IBEAT | ~dwr);
  assign MEM_WRITE = strobe & (state == DBEAT) & dwr;
  assign MEM_ADDRESS = state == IBEAT ? {1'b1, INST_MEM_ADDRESS, beat} : {1'b0, {BW{1'b0}}, DATA_MEM_ADDRESS};
  assign MEM_WRITEDATA = DATA_MEM_WRITEDATA;
  always_comb begin
    state_n = state;
    state_n = grant_d ? DBEAT :
              grant_i ? IBEAT :
              (state == IDONE || state == DDONE) ? IDLE :
              (done && state == DBEAT) ? DDONE :
              (done && beat == BW'(IBLOCK_WORDS - 1)) ? IDONE : state;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      beat <= '0;
      waiting <= 1'b0;
      last_inst <= 1'b1;
      INST_MEM_DATA <= '0;
      DATA_MEM_READDATA <= '0;
    end else begin
      state <= state_n;
      waiting <= strobe;
      if (grant_d || grant_i) last_inst <= grant_i;
      if (done && state == IBEAT) begin
        INST_MEM_DATA[beat*WORD_W +: WORD_W] <= MEM_READDATA;
        beat <= beat + 1'b1;
      end
      if (done && state == DBEAT && !dwr) DATA_MEM_READDATA <= MEM_READDATA;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter against a fixed-latency word memory model
module tb_mem_arbiter;
  localparam int LAT = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic iread = 1'b0, dread = 1'b0, dwrite = 1'b0;
  logic [5:0] iaddr = '0, daddr = '0;
  logic [31:0] dwd = '0, drd, mwd, mrd = '0;
  logic [127:0] idata;
  logic ibw, dbw, mrd_s, mwr_s, mem_busy = 1'b0, mem_w = 1'b0;
  logic [8:0] maddr, mem_a = '0;
  logic [31:0] mem_wd = '0;
  logic [31:0] mem [512];
  int mem_cnt = 0;
  int n_cmp = 0, n_err = 0;
  logic [41:0] obs_q[$];
  logic [127:0] sb[$];
  always #5 clk = ~clk;
  mem_arbiter dut (
    .CLK(clk), .RESET(rst),
    .INST_MEM_READ(iread), .INST_MEM_ADDRESS(iaddr), .INST_MEM_DATA(idata), .INST_MEM_BUSYWAIT(ibw),
    .DATA_MEM_READ(dread), .DATA_MEM_WRITE(dwrite), .DATA_MEM_ADDRESS(daddr),
    .DATA_MEM_WRITEDATA(dwd), .DATA_MEM_READDATA(drd), .DATA_MEM_BUSYWAIT(dbw),
    .MEM_READ(mrd_s), .MEM_WRITE(mwr_s), .MEM_ADDRESS(maddr), .MEM_WRITEDATA(mwd),
    .MEM_READDATA(mrd), .MEM_BUSYWAIT(mem_busy)
  );
  always @(posedge clk) begin
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        mem_busy <= 1'b0;
        if (mem_w) mem[mem_a] <= mem_wd;
        else mrd <= mem[mem_a];
      end else mem_cnt <= mem_cnt - 1;
    end else if (mrd_s || mwr_s) begin
      mem_busy <= 1'b1;
      mem_cnt <= LAT - 1;
      mem_a <= maddr;
      mem_w <= mwr_s;
      mem_wd <= mwd;
      obs_q.push_back({mwr_s, maddr, mwd});
    end
  end
  task automatic wait_bw(input bit inst, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!(inst ? ibw : dbw)) begin
        cyc = i;
        break;
      end
    end
  endtask
  task automatic pop_obs(output logic [41:0] o);
    o = '1;
    if (obs_q.size() > 0) o = obs_q.pop_front();
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (idata !== 128'h0) begin n_err++; $display("FAIL rst_idata: got %h want 0", idata); end
    n_cmp++; if (drd !== 32'h0) begin n_err++; $display("FAIL rst_drd: got %h want 0", drd); end
    n_cmp++; if ({mrd_s, mwr_s} !== 2'b00) begin n_err++; $display("FAIL rst_strobes: got %b want 00", {mrd_s, mwr_s}); end
    n_cmp++; if ({ibw, dbw} !== 2'b00) begin n_err++; $display("FAIL rst_busywait: got %b want 00", {ibw, dbw}); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_data_read();
    int cyc;
    logic [41:0] o;
    logic [127:0] e;
    mem[9'h005] <= 32'hDEADBEEF;
    obs_q.delete();
    sb.push_back(128'hDEADBEEF);
    daddr = 6'h05; dread = 1'b1;
    wait_bw(0, 20, cyc);
    dread = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (cyc !== 7) begin n_err++; $display("FAIL rd_latency: got %0d want 7", cyc); end
    n_cmp++; if (drd !== e[31:0]) begin n_err++; $display("FAIL rd_data: got %h want %h", drd, e[31:0]); end
    pop_obs(o);
    n_cmp++; if (o[41:32] !== {1'b0, 9'h005}) begin n_err++; $display("FAIL rd_addr: got %h want 005 read", o[41:32]); end
    n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL rd_beats: got %0d extra want 0", obs_q.size()); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_inst_refill();
    int cyc;
    logic [41:0] o;
    logic [127:0] e;
    for (int k = 0; k < 4; k++) mem[9'h108 + k] <= 32'(k + 1);
    obs_q.delete();
    sb.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    iaddr = 6'h02; iread = 1'b1;
    wait_bw(1, 40, cyc);
    iread = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (cyc !== 25) begin n_err++; $display("FAIL if_latency: got %0d want 25", cyc); end
    n_cmp++; if (idata !== e) begin n_err++; $display("FAIL if_data: got %h want %h", idata, e); end
    for (int k = 0; k < 4; k++) begin
      pop_obs(o);
      n_cmp++; if (o[41:32] !== {1'b0, 9'(9'h108 + k)}) begin n_err++; $display("FAIL if_addr%0d: got %h want %h", k, o[41:32], 9'h108 + k); end
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_tie();
    int c1, c2, c3, c4;
    logic [41:0] o;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    daddr = 6'h05; iaddr = 6'h02;
    dread = 1'b1; iread = 1'b1;
    wait_bw(0, 20, c1);
    dread = 1'b0;
    wait_bw(1, 40, c2);
    dread = 1'b1;
    wait_bw(0, 20, c3);
    dread = 1'b0;
    wait_bw(1, 40, c4);
    iread = 1'b0;
    n_cmp++; if (c1 !== 7) begin n_err++; $display("FAIL tie_d1: got %0d want 7", c1); end
    n_cmp++; if (c2 !== 26) begin n_err++; $display("FAIL tie_i1: got %0d want 26", c2); end
    n_cmp++; if (c3 !== 8) begin n_err++; $display("FAIL tie_d2: got %0d want 8", c3); end
    n_cmp++; if (c4 !== 26) begin n_err++; $display("FAIL tie_i2: got %0d want 26", c4); end
    n_cmp++; if (obs_q.size() !== 10) begin n_err++; $display("FAIL tie_beats: got %0d want 10", obs_q.size()); end
    pop_obs(o);
    n_cmp++; if (o[40:32] !== 9'h005) begin n_err++; $display("FAIL tie_first: got %h want 005", o[40:32]); end
    pop_obs(o);
    n_cmp++; if (o[40:32] !== 9'h108) begin n_err++; $display("FAIL tie_second: got %h want 108", o[40:32]); end
    repeat (3) pop_obs(o);
    pop_obs(o);
    n_cmp++; if (o[40:32] !== 9'h005) begin n_err++; $display("FAIL tie_third: got %h want 005", o[40:32]); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_write();
    int cyc;
    logic [41:0] o;
    logic [127:0] e;
    obs_q.delete();
    sb.push_back({96'h0, 32'h0000A5A5});
    daddr = 6'h3F; dwd = 32'h0000A5A5; dwrite = 1'b1;
    wait_bw(0, 20, cyc);
    dwrite = 1'b0;
    e = sb.pop_front();
    pop_obs(o);
    n_cmp++; if (cyc !== 7) begin n_err++; $display("FAIL wr_latency: got %0d want 7", cyc); end
    n_cmp++; if (o !== {1'b1, 9'h03F, e[31:0]}) begin n_err++; $display("FAIL wr_beat: got %h want %h", o, {1'b1, 9'h03F, e[31:0]}); end
    n_cmp++; if (drd !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_drd: got %h want deadbeef", drd); end
    n_cmp++; if (mem[9'h03F] !== e[31:0]) begin n_err++; $display("FAIL wr_mem: got %h want %h", mem[9'h03F], e[31:0]); end
    @(negedge clk);
    sb.push_back({96'h0, 32'h00001234});
    daddr = 6'h3E; dwd = 32'h00001234; dwrite = 1'b1; dread = 1'b1;
    wait_bw(0, 20, cyc);
    dwrite = 1'b0; dread = 1'b0;
    e = sb.pop_front();
    pop_obs(o);
    n_cmp++; if (o !== {1'b1, 9'h03E, e[31:0]}) begin n_err++; $display("FAIL rw_beat: got %h want %h", o, {1'b1, 9'h03E, e[31:0]}); end
    n_cmp++; if (drd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rw_drd: got %h want deadbeef", drd); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int cyc, busy_cyc;
    logic rd_seen;
    logic [41:0] o;
    logic [127:0] e;
    obs_q.delete();
    iaddr = 6'h02; iread = 1'b1;
    for (int i = 0; i < 40 && obs_q.size() < 3; i++) @(negedge clk);
    n_cmp++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL rm_reach: got %0d beats want 3", obs_q.size()); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (idata !== 128'h0) begin n_err++; $display("FAIL rm_idata: got %h want 0", idata); end
    n_cmp++; if ({mrd_s, mwr_s} !== 2'b00) begin n_err++; $display("FAIL rm_strobes: got %b want 00", {mrd_s, mwr_s}); end
    n_cmp++; if (ibw !== 1'b1) begin n_err++; $display("FAIL rm_ibw: got %b want 1", ibw); end
    rst = 1'b0;
    obs_q.delete();
    rd_seen = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 20 && mem_busy; i++) begin
      rd_seen |= mrd_s | mwr_s;
      busy_cyc++;
      @(negedge clk);
    end
    n_cmp++; if (rd_seen !== 1'b0 || busy_cyc == 0) begin n_err++; $display("FAIL rm_no_grant: got strobe %b over %0d busy cycles want 0", rd_seen, busy_cyc); end
    sb.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    wait_bw(1, 40, cyc);
    iread = 1'b0;
    e = sb.pop_front();
    pop_obs(o);
    n_cmp++; if (cyc !== 25) begin n_err++; $display("FAIL rm_latency: got %0d want 25", cyc); end
    n_cmp++; if (idata !== e) begin n_err++; $display("FAIL rm_data: got %h want %h", idata, e); end
    n_cmp++; if (o[40:32] !== 9'h108) begin n_err++; $display("FAIL rm_restart: got %h want 108", o[40:32]); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int c1, c2;
    logic [127:0] e;
    for (int k = 0; k < 4; k++) mem[9'h10C + k] <= 32'hB0 + 32'(k);
    sb.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    sb.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
    iaddr = 6'h02; iread = 1'b1;
    wait_bw(1, 40, c1);
    e = sb.pop_front();
    n_cmp++; if (c1 !== 25) begin n_err++; $display("FAIL b2b_lat1: got %0d want 25", c1); end
    n_cmp++; if (idata !== e) begin n_err++; $display("FAIL b2b_data1: got %h want %h", idata, e); end
    n_cmp++; if (mrd_s !== 1'b0) begin n_err++; $display("FAIL b2b_done_rd: got %b want 0", mrd_s); end
    iaddr = 6'h03;
    @(negedge clk);
    n_cmp++; if ({mrd_s, ibw} !== 2'b01) begin n_err++; $display("FAIL b2b_idle: got rd,bw %b want 01", {mrd_s, ibw}); end
    @(negedge clk);
    n_cmp++; if ({mrd_s, maddr} !== {1'b1, 9'h10C}) begin n_err++; $display("FAIL b2b_issue: got %h want %h", {mrd_s, maddr}, {1'b1, 9'h10C}); end
    wait_bw(1, 40, c2);
    iread = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (c2 !== 24) begin n_err++; $display("FAIL b2b_lat2: got %0d want 24", c2); end
    n_cmp++; if (idata !== e) begin n_err++; $display("FAIL b2b_data2: got %h want %h", idata, e); end
    n_cmp++; if (mrd_s !== 1'b0) begin n_err++; $display("FAIL b2b_done2_rd: got %b want 0", mrd_s); end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= '0;
    test_reset();
    test_data_read();
    test_inst_refill();
    test_tie();
    test_write();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
